// File: rtl/obi_byteram_pkg.sv
// Shared types and helpers for the dual-port OBI byte memory.
package obi_byteram_pkg;

  localparam int unsigned LFSR_W = 16;
  // Galois form of x^16+x^14+x^13+x^11+1, shifting right
  localparam logic [LFSR_W-1:0] LFSR_POLY = 16'hB400;

  typedef struct packed {
    logic rvalid;
    logic err;
  } resp_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

  function automatic logic in_range(input logic [31:0] addr, input int unsigned aw);
    return (addr >> aw) == 32'd0;
  endfunction

endpackage

// File: rtl/obi_byteram_port.sv
// One req/gnt/rvalid port: random grant stalls and a fixed-latency response pipe.
module obi_byteram_port
  import obi_byteram_pkg::*;
#(
  parameter int unsigned       RDATA_W   = 32,
  parameter int unsigned       LATENCY   = 1,
  parameter int unsigned       MAX_STALL = 7,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               stall_en_i,
  input  logic               req_i,
  output logic               gnt_o,
  input  logic               err_i,
  input  logic [RDATA_W-1:0] rdata_i,
  output logic               rvalid_o,
  output logic               err_o,
  output logic [RDATA_W-1:0] rdata_o
);

  localparam int unsigned CNT_W = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;

  typedef struct packed {
    resp_t              hdr;
    logic [RDATA_W-1:0] rdata;
  } port_resp_t;

  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [LFSR_W-1:0]          lfsr_q, lfsr_d;
  port_resp_t [LATENCY-1:0]   pipe_q;
  port_resp_t                 pipe_d;
  logic                       xfer;

  assign gnt_o = req_i && (cnt_q == '0);
  assign xfer  = req_i && gnt_o;

  // Next stall count, LFSR step and the response entering the pipe
  always_comb begin
    lfsr_d = lfsr_q;
    cnt_d  = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
    pipe_d = '0;
    if (xfer) begin
      lfsr_d = lfsr_next(lfsr_q);
      if (stall_en_i) begin
        cnt_d = CNT_W'(lfsr_q % LFSR_W'(MAX_STALL + 1));
      end
      pipe_d.hdr.rvalid = 1'b1;
      pipe_d.hdr.err    = err_i;
      pipe_d.rdata      = err_i ? '0 : rdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      lfsr_q <= LFSR_SEED;
      pipe_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      pipe_q[0] <= pipe_d;
      for (int i = 1; i < int'(LATENCY); i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign rvalid_o = pipe_q[LATENCY-1].hdr.rvalid;
  assign err_o    = pipe_q[LATENCY-1].hdr.err;
  assign rdata_o  = pipe_q[LATENCY-1].rdata;

endmodule

// File: rtl/obi_byteram.sv
// Byte-addressable memory with a wide read-only fetch port and a 32-bit data port.
module obi_byteram
  import obi_byteram_pkg::*;
#(
  parameter int unsigned       ADDR_WIDTH        = 16,
  parameter int unsigned       INSTR_RDATA_WIDTH = 128,
  parameter int unsigned       INSTR_LATENCY     = 1,
  parameter int unsigned       DATA_LATENCY      = 1,
  parameter int unsigned       MAX_STALL         = 7,
  parameter logic [LFSR_W-1:0] LFSR_SEED_I       = 16'hACE1,
  parameter logic [LFSR_W-1:0] LFSR_SEED_D       = 16'h1D0F
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         stall_en_i,
  input  logic                         instr_req_i,
  output logic                         instr_gnt_o,
  input  logic [31:0]                  instr_addr_i,
  output logic                         instr_rvalid_o,
  output logic [INSTR_RDATA_WIDTH-1:0] instr_rdata_o,
  output logic                         instr_err_o,
  input  logic                         data_req_i,
  output logic                         data_gnt_o,
  input  logic [31:0]                  data_addr_i,
  input  logic                         data_we_i,
  input  logic [3:0]                   data_be_i,
  input  logic [31:0]                  data_wdata_i,
  output logic                         data_rvalid_o,
  output logic [31:0]                  data_rdata_o,
  output logic                         data_err_o
);

  localparam int unsigned MEM_BYTES = 2 ** ADDR_WIDTH;
  localparam int unsigned IBYTES    = INSTR_RDATA_WIDTH / 8;
  localparam int unsigned DBYTES    = 4;

  logic [7:0]                   mem_q [MEM_BYTES];
  logic [ADDR_WIDTH-1:0]        ibase, dbase;
  logic                         instr_ok, data_ok, data_xfer;
  logic [INSTR_RDATA_WIDTH-1:0] instr_rd;
  logic [31:0]                  data_rd;

  assign instr_ok  = in_range(instr_addr_i, ADDR_WIDTH);
  assign data_ok   = in_range(data_addr_i, ADDR_WIDTH);
  assign ibase     = instr_addr_i[ADDR_WIDTH-1:0] & ~ADDR_WIDTH'(IBYTES - 1);
  assign dbase     = data_addr_i[ADDR_WIDTH-1:0] & ~ADDR_WIDTH'(DBYTES - 1);
  assign data_xfer = data_req_i && data_gnt_o;

  // Reads see memory as it was before this cycle's write lands
  always_comb begin
    instr_rd = '0;
    for (int i = 0; i < int'(IBYTES); i++) begin
      instr_rd[8*i +: 8] = mem_q[ibase + ADDR_WIDTH'(i)];
    end
    data_rd = '0;
    for (int i = 0; i < int'(DBYTES); i++) begin
      data_rd[8*i +: 8] = mem_q[dbase + ADDR_WIDTH'(i)];
    end
    if (data_we_i) begin
      data_rd = '0;
    end
  end

  // Contents survive reset; out-of-range writes are dropped
  always_ff @(posedge clk_i) begin
    if (data_xfer && data_we_i && data_ok) begin
      if (data_be_i[0]) mem_q[dbase]                    <= data_wdata_i[7:0];
      if (data_be_i[1]) mem_q[dbase | ADDR_WIDTH'(1)]   <= data_wdata_i[15:8];
      if (data_be_i[2]) mem_q[dbase | ADDR_WIDTH'(2)]   <= data_wdata_i[23:16];
      if (data_be_i[3]) mem_q[dbase | ADDR_WIDTH'(3)]   <= data_wdata_i[31:24];
    end
  end

  obi_byteram_port #(
    .RDATA_W   (INSTR_RDATA_WIDTH),
    .LATENCY   (INSTR_LATENCY),
    .MAX_STALL (MAX_STALL),
    .LFSR_SEED (LFSR_SEED_I)
  ) u_instr_port (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .stall_en_i (stall_en_i),
    .req_i      (instr_req_i),
    .gnt_o      (instr_gnt_o),
    .err_i      (!instr_ok),
    .rdata_i    (instr_rd),
    .rvalid_o   (instr_rvalid_o),
    .err_o      (instr_err_o),
    .rdata_o    (instr_rdata_o)
  );

  obi_byteram_port #(
    .RDATA_W   (32),
    .LATENCY   (DATA_LATENCY),
    .MAX_STALL (MAX_STALL),
    .LFSR_SEED (LFSR_SEED_D)
  ) u_data_port (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .stall_en_i (stall_en_i),
    .req_i      (data_req_i),
    .gnt_o      (data_gnt_o),
    .err_i      (!data_ok),
    .rdata_i    (data_rd),
    .rvalid_o   (data_rvalid_o),
    .err_o      (data_err_o),
    .rdata_o    (data_rdata_o)
  );

endmodule

// File: tb/tb_obi_byteram.sv
// Scoreboard bench for obi_byteram: drivers push expected responses, monitors pop and compare.
module tb_obi_byteram;

  localparam int ILAT = 1;
  localparam int DLAT = 3;
  localparam int MAXS = 7;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         stall_en;
  logic         instr_req;
  logic         instr_gnt;
  logic [31:0]  instr_addr;
  logic         instr_rvalid;
  logic [127:0] instr_rdata;
  logic         instr_err;
  logic         data_req;
  logic         data_gnt;
  logic [31:0]  data_addr;
  logic         data_we;
  logic [3:0]   data_be;
  logic [31:0]  data_wdata;
  logic         data_rvalid;
  logic [31:0]  data_rdata;
  logic         data_err;

  obi_byteram #(
    .ADDR_WIDTH        (16),
    .INSTR_RDATA_WIDTH (128),
    .INSTR_LATENCY     (ILAT),
    .DATA_LATENCY      (DLAT),
    .MAX_STALL         (MAXS),
    .LFSR_SEED_I       (16'hACE1),
    .LFSR_SEED_D       (16'h1D0F)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .stall_en_i     (stall_en),
    .instr_req_i    (instr_req),
    .instr_gnt_o    (instr_gnt),
    .instr_addr_i   (instr_addr),
    .instr_rvalid_o (instr_rvalid),
    .instr_rdata_o  (instr_rdata),
    .instr_err_o    (instr_err),
    .data_req_i     (data_req),
    .data_gnt_o     (data_gnt),
    .data_addr_i    (data_addr),
    .data_we_i      (data_we),
    .data_be_i      (data_be),
    .data_wdata_i   (data_wdata),
    .data_rvalid_o  (data_rvalid),
    .data_rdata_o   (data_rdata),
    .data_err_o     (data_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           due;
    logic         err;
    logic [127:0] rdata;
  } exp_t;

  exp_t iq[$];
  exp_t dq[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   i_gnt = 0, i_rv = 0, d_gnt = 0, d_rv = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [31:0] pat(input int j);
    return 32'hC0DE_0000 + 32'(j) * 32'h1111;
  endfunction

  always @(negedge clk) begin : mon_instr
    exp_t e;
    if (mon_en) begin
      if (iq.size() > 0 && iq[0].due == cyc) begin
        e = iq.pop_front();
        chk("instr_rvalid", 128'(instr_rvalid), 128'(1'b1));
        chk("instr_rdata", instr_rdata, e.rdata);
        chk("instr_err", 128'(instr_err), 128'(e.err));
        if (instr_rvalid) i_rv++;
      end else begin
        chk("instr_idle_rvalid", 128'(instr_rvalid), 128'(1'b0));
        chk("instr_idle_data", instr_rdata | 128'(instr_err), 128'(0));
      end
    end
  end

  always @(negedge clk) begin : mon_data
    exp_t e;
    if (mon_en) begin
      if (dq.size() > 0 && dq[0].due == cyc) begin
        e = dq.pop_front();
        chk("data_rvalid", 128'(data_rvalid), 128'(1'b1));
        chk("data_rdata", 128'(data_rdata), e.rdata);
        chk("data_err", 128'(data_err), 128'(e.err));
        if (data_rvalid) d_rv++;
      end else begin
        chk("data_idle_rvalid", 128'(data_rvalid), 128'(1'b0));
        chk("data_idle_data", 128'(data_rdata) | 128'(data_err), 128'(0));
      end
    end
  end

  // Waits (bounded) at negedges for a grant on the chosen port
  task automatic wait_gnt(input bit dport, output bit ok);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(dport ? data_gnt : instr_gnt) && n < 32);
    ok = dport ? data_gnt : instr_gnt;
    chk(dport ? "data_gnt" : "instr_gnt", 128'(ok), 128'(1'b1));
  endtask

  task automatic instr_rd(input logic [31:0] a, input logic [127:0] exp, input logic err);
    bit ok;
    @(posedge clk); #1;
    instr_req  = 1'b1;
    instr_addr = a;
    wait_gnt(1'b0, ok);
    if (ok) begin
      iq.push_back('{due: cyc + ILAT, err: err, rdata: exp});
      i_gnt++;
      @(posedge clk); #1;
    end
    instr_req = 1'b0;
  endtask

  task automatic data_txn(input logic [31:0] a, input logic we, input logic [3:0] be,
                          input logic [31:0] wd, input logic [31:0] exp, input logic err);
    bit ok;
    @(posedge clk); #1;
    data_req   = 1'b1;
    data_addr  = a;
    data_we    = we;
    data_be    = be;
    data_wdata = wd;
    wait_gnt(1'b1, ok);
    if (ok) begin
      dq.push_back('{due: cyc + DLAT, err: err, rdata: 128'(exp)});
      d_gnt++;
      @(posedge clk); #1;
    end
    data_req = 1'b0;
    data_we  = 1'b0;
  endtask

  // Back-to-back reads of the pattern words at 0x40..0x5C
  task automatic data_stream(input int n, input bit stalls);
    bit ok;
    int last_g = 0;
    int gap;
    int stalled = 0;
    @(posedge clk); #1;
    data_req = 1'b1;
    data_we  = 1'b0;
    data_be  = 4'h0;
    for (int k = 0; k < n; k++) begin
      data_addr = 32'h40 + 32'(4 * (k % 8));
      wait_gnt(1'b1, ok);
      if (!ok) break;
      if (k > 0) begin
        gap = cyc - last_g - 1;
        if (stalls) chk("stall_gap_le_max", 128'(gap <= MAXS), 128'(1'b1));
        else        chk("b2b_gap", 128'(gap), 128'(0));
        if (gap > 0) stalled++;
      end
      last_g = cyc;
      dq.push_back('{due: cyc + DLAT, err: 1'b0, rdata: 128'(pat(k % 8))});
      d_gnt++;
      @(posedge clk); #1;
    end
    data_req = 1'b0;
    if (stalls) chk("stalls_observed", 128'(stalled > 0), 128'(1'b1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual still running, required finished by 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    int rv_before;
    int g;
    rst_n      = 1'b0;
    stall_en   = 1'b0;
    instr_req  = 1'b1;
    instr_addr = 32'h0;
    data_req   = 1'b1;
    data_addr  = 32'h0;
    data_we    = 1'b0;
    data_be    = 4'h0;
    data_wdata = 32'h0;

    // Reset values and gnt == req while counters are cleared
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_instr_gnt", 128'(instr_gnt), 128'(1'b1));
    chk("rst_data_gnt", 128'(data_gnt), 128'(1'b1));
    chk("rst_instr_out", instr_rdata | 128'({instr_rvalid, instr_err}), 128'(0));
    chk("rst_data_out", 128'(data_rdata) | 128'({data_rvalid, data_err}), 128'(0));
    @(posedge clk); #1;
    instr_req = 1'b0;
    data_req  = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Preload bytes 00..0F through the data port
    data_txn(32'h0, 1'b1, 4'hF, 32'h03020100, 32'h0, 1'b0);
    data_txn(32'h4, 1'b1, 4'hF, 32'h07060504, 32'h0, 1'b0);
    data_txn(32'h8, 1'b1, 4'hF, 32'h0B0A0908, 32'h0, 1'b0);
    data_txn(32'hC, 1'b1, 4'hF, 32'h0F0E0D0C, 32'h0, 1'b0);
    instr_rd(32'h4, 128'h0F0E0D0C_0B0A0908_07060504_03020100, 1'b0);

    // Byte-enable write and unaligned read
    data_txn(32'h10, 1'b1, 4'hF, 32'h0, 32'h0, 1'b0);
    data_txn(32'h10, 1'b1, 4'b0101, 32'hAABBCCDD, 32'h0, 1'b0);
    data_txn(32'h10, 1'b0, 4'hF, 32'h0, 32'h00BB00DD, 1'b0);
    data_txn(32'h13, 1'b0, 4'h0, 32'h0, 32'h00BB00DD, 1'b0);

    // Same-cycle instr read and data write: read sees old bytes
    fork
      instr_rd(32'h0, 128'h0F0E0D0C_0B0A0908_07060504_03020100, 1'b0);
      data_txn(32'h0, 1'b1, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0);
    join
    instr_rd(32'h8, 128'h0F0E0D0C_0B0A0908_07060504_DEADBEEF, 1'b0);

    // Range boundaries
    data_txn(32'h0001_0000, 1'b1, 4'hF, 32'h12345678, 32'h0, 1'b1);
    data_txn(32'h0, 1'b0, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0);
    data_txn(32'h0000_FFFC, 1'b1, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0);
    data_txn(32'h0000_FFFC, 1'b0, 4'hF, 32'h0, 32'hCAFEF00D, 1'b0);
    data_txn(32'h0001_0000, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1);
    instr_rd(32'hFFFF_0000, 128'h0, 1'b1);

    // Streams: no stalls, then random stalls
    for (int j = 0; j < 8; j++) data_txn(32'h40 + 32'(4 * j), 1'b1, 4'hF, pat(j), 32'h0, 1'b0);
    data_stream(8, 1'b0);
    @(posedge clk); #1;
    stall_en = 1'b1;
    data_stream(200, 1'b1);
    repeat (DLAT + 2) @(posedge clk);

    // Reset one cycle after a grant drops the in-flight response
    #1;
    data_req  = 1'b1;
    data_we   = 1'b0;
    data_addr = 32'h40;
    wait_gnt(1'b1, ok);
    @(posedge clk); #1;
    data_req  = 1'b0;
    rst_n     = 1'b0;
    rv_before = d_rv;
    repeat (3) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    data_req  = 1'b1;
    data_addr = 32'h44;
    @(negedge clk);
    chk("rst_drop_rvalid", 128'(d_rv), 128'(rv_before));
    chk("rst_gnt_eq_req", 128'(data_gnt), 128'(1'b1));
    if (data_gnt) begin
      dq.push_back('{due: cyc + DLAT, err: 1'b0, rdata: 128'(pat(1))});
      d_gnt++;
    end
    g = cyc;
    @(posedge clk); #1;
    data_addr = 32'h48;
    wait_gnt(1'b1, ok);
    if (ok) begin
      chk("seed_stall_gap", 128'(cyc - g - 1), 128'(7));
      dq.push_back('{due: cyc + DLAT, err: 1'b0, rdata: 128'(pat(2))});
      d_gnt++;
      @(posedge clk); #1;
    end
    data_req = 1'b0;
    stall_en = 1'b0;

    // Writes made before the reset persist
    instr_rd(32'h0, 128'h0F0E0D0C_0B0A0908_07060504_DEADBEEF, 1'b0);

    repeat (DLAT + 4) @(posedge clk);
    @(negedge clk);
    chk("instr_q_drained", 128'(iq.size()), 128'(0));
    chk("data_q_drained", 128'(dq.size()), 128'(0));
    chk("instr_rv_eq_gnt", 128'(i_rv), 128'(i_gnt));
    chk("data_rv_eq_gnt", 128'(d_rv), 128'(d_gnt));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
